// File: rtl/obuf_drain.sv
// obuf_drain: sweeps the accumulation buffer, requantizes each entry (rounding shift + saturation), streams it out.
// Latency: start -> first element 3 cycles, then 1 element/cycle; done_o one cycle after the last transfer.
// Backpressure: oready_i low stalls a 2-entry output FIFO; address issue throttles so nothing is dropped.
// Optional OBUF_DRAIN_RELU_EN: negative results are clamped to zero before saturation.
module obuf_drain #(
    parameter int ACC_W   = 20,
    parameter int DEPTH   = 8,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SHIFT_W-1:0]       shift_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH)-1:0] raddr_o,
    input  logic [ACC_W-1:0]         rdata_i,
    output logic [OUT_W-1:0]         odata_o,
    output logic [$clog2(DEPTH)-1:0] oidx_o,
    output logic                     ovalid_o,
    input  logic                     oready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int XW = ACC_W + 1;
    localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (OUT_W-1)) - 1);
    localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (OUT_W-1)));

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0]    idx;
        logic [OUT_W-1:0] dat;
    } elem_t;

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [AW-1:0]      issue_cnt_q, issue_cnt_d;
    logic [AW-1:0]      raddr_q, raddr_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    elem_t              head_q, head_d;
    elem_t              tail_q, tail_d;
    logic [1:0]         count_q, count_d;

    logic               pop;
    logic               issue;
    logic [2:0]         occ;
    elem_t              result;

    logic [31:0]             s_amt;
    logic signed [XW-1:0]    x_ext;
    logic signed [XW-1:0]    rnd;
    logic signed [XW-1:0]    y;

    // Requantize the entry returning this cycle; tagged with the address issued last cycle.
    always_comb begin
        s_amt = (32'(shift_q) > 32'(ACC_W-1)) ? 32'(ACC_W-1) : 32'(shift_q);
        x_ext = {rdata_i[ACC_W-1], rdata_i};
        rnd   = '0;
        if (s_amt != 32'd0) begin
            rnd = XW'(1) << (s_amt - 32'd1);
        end
        y = (x_ext + rnd) >>> s_amt;
`ifdef OBUF_DRAIN_RELU_EN
        if (y[XW-1]) begin
            y = '0;
        end
`endif
        if (y > SAT_MAX) begin
            y = SAT_MAX;
        end else if (y < SAT_MIN) begin
            y = SAT_MIN;
        end
        result.idx = raddr_q;
        result.dat = y[OUT_W-1:0];
    end

    always_comb begin
        pop   = (count_q != 2'd0) && oready_i;
        // Occupancy the FIFO will have after this cycle, counting the read still in flight.
        occ   = 3'(count_q) - 3'(pop) + 3'(inflight_q);
        issue = (state_q == READ) && (occ < 3'd2);

        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            head_d = tail_q;
        end
        if (inflight_q) begin
            if ((count_q - 2'(pop)) == 2'd0) begin
                head_d = result;
            end else begin
                tail_d = result;
            end
        end
        count_d = count_q - 2'(pop) + 2'(inflight_q);

        state_d     = state_q;
        shift_d     = shift_q;
        issue_cnt_d = issue_cnt_q;
        raddr_d     = issue ? issue_cnt_q : raddr_q;
        inflight_d  = issue;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shift_d     = shift_i;
                    issue_cnt_d = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == AW'(DEPTH-1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (!inflight_q && (count_d == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == READ) || (state_d == FLUSH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            issue_cnt_q <= '0;
            raddr_q     <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            issue_cnt_q <= issue_cnt_d;
            raddr_q     <= raddr_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // The address must show in the issue cycle itself, so raddr_o bypasses the register.
    assign raddr_o  = raddr_d;
    assign odata_o  = head_q.dat;
    assign oidx_o   = head_q.idx;
    assign ovalid_o = (count_q != 2'd0);
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: doc/obuf_drain.md
# obuf_drain

Drain/post-processing stage directly downstream of the output accumulation buffer. After a tile completes, it sweeps the buffer's read address from 0 to DEPTH-1 and absorbs the buffer's one-cycle registered read latency. Each signed accumulator is requantized (rounding arithmetic right shift, saturation to OUT_W) and streamed out over a valid/ready interface with full backpressure support.

## Interface
Parameters:
- ACC_W, 20, accumulator width read from the buffer (signed two's complement)
- DEPTH, 8, number of buffer entries to drain per tile
- OUT_W, 8, output element width (signed)
- SHIFT_W, 5, width of the requantization shift amount

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse: begin draining a tile; ignored while busy_o=1
- shift_i  in  SHIFT_W  right-shift amount, latched when start_i is accepted
- busy_o  out  1  high from the cycle after start acceptance until done_o
- done_o  out  1  one-cycle pulse after the final output handshake
- raddr_o  out  $clog2(DEPTH)  buffer read address
- rdata_i  in  ACC_W  buffer read data; holds entry raddr_o(cycle N) during cycle N+1
- odata_o  out  OUT_W  requantized element
- oidx_o  out  $clog2(DEPTH)  entry index of odata_o
- ovalid_o  out  1  odata_o/oidx_o valid
- oready_i  in  1  consumer ready; a transfer occurs when ovalid_o & oready_i

## Operation
- FSM states:
  - IDLE: start_i=1 latches shift_i, clears the issue and return counters, and moves to READ.
  - READ: issues addresses 0..DEPTH-1 in order. After DEPTH-1 is issued, moves to FLUSH.
  - FLUSH: waits until the pipeline and FIFO are empty, then moves to DONE.
  - DONE: asserts done_o for one cycle and returns to IDLE.
- Issue rule: an address is issued in cycle t only when (fifo_count - pop_t + inflight) < 2.
  - pop_t = ovalid_o & oready_i.
  - inflight = 1 if an address was issued in cycle t-1.
  - Outside an issue cycle, raddr_o holds its last value. Tracking is done with an internal issue strobe, not raddr_o changes.
- The return path captures rdata_i one cycle after each issue and tags it with the issued index.
- Arithmetic (in ACC_W+1 bits):
  - s = min(shift_r, ACC_W-1).
  - If s=0, y = x. If s>0, y = (x + 2^(s-1)) >>> s.
  - y is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Results enter a 2-entry output FIFO. odata_o, oidx_o and ovalid_o come from the FIFO head.
- Elements leave strictly in index order. No element is dropped or duplicated under any oready_i pattern.
- A start_i pulse while busy_o=1 has no effect; shift_r is unchanged.

## Timing
- Reset values: busy_o=0, done_o=0, raddr_o=0, odata_o=0, oidx_o=0, ovalid_o=0. FSM is in IDLE, FIFO is empty.
- Latency with oready_i held high:
  - start_i in cycle 0.
  - raddr_o=0 in cycle 1; rdata_i entry 0 in cycle 2.
  - ovalid_o with entry 0 in cycle 3.
  - Entry k appears in cycle 3+k. For DEPTH=8 the last entry is in cycle 10.
  - done_o in cycle 11, and busy_o falls in the same cycle.
- Throughput is 1 element/cycle when oready_i=1 continuously.
- While ovalid_o=1 and oready_i=0, odata_o and oidx_o hold stable.
- Asserting rst_i mid-tile aborts immediately: all outputs return to their reset values and the FSM returns to IDLE. No done_o pulse is produced.
- start_i in the same cycle as done_o is ignored (the FSM is not yet in IDLE).

## Configuration
- OBUF_DRAIN_RELU_EN defined: after the shift and before saturation, negative y is forced to 0, so odata_o ranges over 0..2^(OUT_W-1)-1.
- Undefined: signed results pass through to saturation unchanged.

## Test plan
- Buffer entries 0..7, shift 0, oready_i=1 -> odata 0..7 in cycles 3..10 with oidx 0..7; done_o in cycle 11.
- Entries 1000, -1000, 24, -24, 23, 0x7FFFF, -0x80000, 8; shift 4 -> 63, -62, 2, -1, 1, 127, -128, 1 (no ReLU).
- Same data with OBUF_DRAIN_RELU_EN -> 63, 0, 2, 0, 1, 127, 0, 1.
- oready_i random 30% duty -> all 8 entries emitted in order exactly once; data stable while stalled; raddr_o never runs more than 2 ahead of the consumer.
- start_i re-pulsed in cycle 4 with a different shift_i -> ignored; outputs use the original shift.
- rst_i asserted in cycle 6 -> all outputs 0 next edge; a new start then completes a full clean tile.
